// File: rtl/riscv_sys_pkg.sv
// rtl/riscv_sys_pkg.sv - shared constants and the loader state encoding
package riscv_sys_pkg;

    localparam int IMEM_ADDR_W = 9;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word assembler with a one-cycle word strobe
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_end,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] acc;

    assign word_end = in_valid && (cnt == 2'd3);

    // Bytes shift in from the top so the first byte ends up in bits [7:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            acc        <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt <= '0;
                acc <= '0;
            end else if (in_valid) begin
                cnt <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    word       <= {in_data, acc};
                    word_valid <= 1'b1;
                end else begin
                    acc <= {in_data, acc[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a checksummed byte stream into instruction memory
module imem_loader
    import riscv_sys_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MAX_WORDS = 128,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        words_loaded
);

    loader_state_t state, state_next;

    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] word_cnt;
    logic [7:0]  csum;
    logic        accept;
    logic        data_fire;
    logic        start_ok;
    logic        len_bad;
    logic        word_end;

    assign rx_ready  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                       (state == ST_DATA)   || (state == ST_CSUM);
    assign busy      = rx_ready;
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERR);
    assign cpu_rst   = (state != ST_DONE);
    assign accept    = rx_valid && rx_ready;
    assign data_fire = accept && (state == ST_DATA);
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign len_full  = {rx_data, len_lo};
    assign len_bad   = (len_full == 16'd0) || (len_full > 16'(MAX_WORDS));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .in_valid   (data_fire),
        .in_data    (rx_data),
        .word_end   (word_end),
        .word_valid (mem_we),
        .word       (mem_din)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start_ok) state_next = ST_LEN_LO;
            ST_LEN_LO:                if (accept) state_next = ST_LEN_HI;
            ST_LEN_HI:                if (accept) state_next = len_bad ? ST_ERR : ST_DATA;
            ST_DATA:                  if (word_end && (word_cnt + 16'd1 == len)) state_next = ST_CSUM;
            ST_CSUM:                  if (accept) state_next = (rx_data == csum) ? ST_DONE : ST_ERR;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo       <= '0;
            len          <= '0;
            word_cnt     <= '0;
            csum         <= '0;
            words_loaded <= '0;
            mem_addr     <= '0;
        end else if (start_ok) begin
            word_cnt     <= '0;
            csum         <= '0;
            words_loaded <= '0;
        end else begin
            if (accept && (state == ST_LEN_LO)) len_lo <= rx_data;
            if (accept && (state == ST_LEN_HI)) len    <= len_full;
            if (data_fire) csum <= csum ^ rx_data;
            // Address is registered alongside the packed word so both appear in the write cycle.
            if (word_end) begin
                mem_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'({word_cnt, 2'b00});
                word_cnt <= word_cnt + 16'd1;
                if (words_loaded != 8'hFF) words_loaded <= words_loaded + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  words_loaded;

    int checks = 0;
    int failures = 0;

    logic [8:0]  wa[$];
    logic [31:0] wd[$];

    typedef struct {
        int                    nbytes;
        logic [0:11][7:0]      b;
        int                    nwr;
        logic [0:1][8:0]       a;
        logic [0:1][31:0]      d;
        logic                  exp_done;
        logic                  exp_err;
        logic [7:0]            exp_wl;
    } vec_t;

    vec_t vecs[5];
    logic [7:0] good[11] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                             8'hB3, 8'h05, 8'hA5, 8'h00, 8'h15};

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_din);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cpu_rst"}, cpu_rst, 1);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_words"}, words_loaded, 0);
    endtask

    task automatic check_good_result(input string tag);
        check({tag, "_nwr"}, wa.size(), 2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, wa[0], 9'h000);
            check({tag, "_d0"}, wd[0], 32'h00100513);
            check({tag, "_a1"}, wa[1], 9'h004);
            check({tag, "_d1"}, wd[1], 32'h00A505B3);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_error"}, error, 0);
        check({tag, "_cpu_rst"}, cpu_rst, 0);
        check({tag, "_words"}, words_loaded, 2);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; rx_data = '0; rx_valid = 1'b0;

        vecs[0] = '{11, {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hA5, 8'h00, 8'h15, 8'h00},
                    2, {9'h000, 9'h004}, {32'h00100513, 32'h00A505B3}, 1'b1, 1'b0, 8'd2};
        vecs[1] = '{11, {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hA5, 8'h00, 8'h14, 8'h00},
                    2, {9'h000, 9'h004}, {32'h00100513, 32'h00A505B3}, 1'b0, 1'b1, 8'd2};
        vecs[2] = '{2, {8'h00, 8'h00, 80'h0}, 0, {9'h0, 9'h0}, {32'h0, 32'h0}, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{2, {8'h81, 8'h00, 80'h0}, 0, {9'h0, 9'h0}, {32'h0, 32'h0}, 1'b0, 1'b1, 8'd0};
        vecs[4] = '{7, {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 40'h0},
                    1, {9'h000, 9'h0}, {32'hDDCCBBAA, 32'h0}, 1'b1, 1'b0, 8'd1};

        #12;
        check_idle_outputs("reset");
        rst = 1'b1;
        idle(3);
        check_idle_outputs("post_reset");

        for (int v = 0; v < 5; v++) begin
            wa.delete();
            wd.delete();
            pulse_start();
            check($sformatf("v%0d_busy", v), busy, 1);
            check($sformatf("v%0d_cpu_rst_loading", v), cpu_rst, 1);
            for (int k = 0; k < vecs[v].nbytes; k++) send_byte(vecs[v].b[k]);
            check($sformatf("v%0d_done", v), done, vecs[v].exp_done);
            check($sformatf("v%0d_error", v), error, vecs[v].exp_err);
            check($sformatf("v%0d_cpu_rst", v), cpu_rst, !vecs[v].exp_done);
            check($sformatf("v%0d_rx_ready", v), rx_ready, 0);
            check($sformatf("v%0d_words", v), words_loaded, vecs[v].exp_wl);
            idle(1);
            check($sformatf("v%0d_nwr", v), wa.size(), vecs[v].nwr);
            for (int w = 0; w < vecs[v].nwr && w < wa.size(); w++) begin
                check($sformatf("v%0d_addr%0d", v, w), wa[w], vecs[v].a[w]);
                check($sformatf("v%0d_data%0d", v, w), wd[w], vecs[v].d[w]);
            end
        end

        // Maximum-length program: word i = i, checksum of bytes 0..127 is zero.
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'h80); send_byte(8'h00);
        for (int i = 0; i < 128; i++) begin
            send_byte(8'(i)); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end
        send_byte(8'h00);
        check("max_done", done, 1);
        check("max_words", words_loaded, 128);
        check("max_nwr", wa.size(), 128);
        if (wa.size() == 128) begin
            check("max_last_addr", wa[127], 9'h1FC);
            check("max_last_data", wd[127], 32'd127);
            check("max_mid_addr", wa[64], 9'h100);
        end

        // Gaps on alternate cycles plus a start pulse that must be ignored mid-DATA.
        wa.delete(); wd.delete();
        pulse_start();
        for (int k = 0; k < 11; k++) begin
            send_byte(good[k]);
            if (k == 5) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("gap_start_ignored_busy", busy, 1);
            end else begin
                idle(1);
            end
        end
        check_good_result("gap");

        // Asynchronous reset landing in the write cycle of the second word.
        wa.delete(); wd.delete();
        pulse_start();
        for (int k = 0; k < 10; k++) send_byte(good[k]);
        check("rst_pre_mem_we", mem_we, 1);
        check("rst_pre_addr", mem_addr, 9'h004);
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        #3 rst = 1'b1;
        idle(3);
        check_idle_outputs("after_rst");
        wa.delete(); wd.delete();
        pulse_start();
        for (int k = 0; k < 11; k++) send_byte(good[k]);
        idle(1);
        check_good_result("reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
